// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised multi-read-port register file with bypass and hardware clear sequencer
module regfile_multiport #(
  parameter int DATA_WIDTH  = 32,
  parameter int WORDS       = 32,
  parameter int SELECT_SIZE = 5,
  parameter int READ_PORTS  = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               reg_we_i,
  input  logic [SELECT_SIZE-1:0]             reg_dst_i,
  input  logic [DATA_WIDTH-1:0]              data_i,
  input  logic [READ_PORTS*SELECT_SIZE-1:0]  reg_src_i,
  output logic [READ_PORTS*DATA_WIDTH-1:0]   src_o,
  input  logic                               clear_i,
  output logic                               busy_o
);
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  localparam logic [SELECT_SIZE:0]   LP_WORDS = (SELECT_SIZE+1)'(WORDS);
  localparam logic [SELECT_SIZE-1:0] LP_LAST  = SELECT_SIZE'(WORDS-1);
  state_t                  r_state, w_state_nxt;
  logic [SELECT_SIZE-1:0]  r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0]   r_bank [WORDS];
  logic                    w_we;
  assign busy_o = (r_state == S_CLEAR);
  assign w_we   = (r_state == S_IDLE) && !reg_we_i && ({1'b0, reg_dst_i} < LP_WORDS) &&
                  !(ZERO_REG != 0 && reg_dst_i == '0);
  // State and clear index; reset restarts the clear sequence from index 0
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end
  // Clear walks every index once then returns to idle; clear_i only honoured in idle
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == S_CLEAR) begin
      w_state_nxt = (r_idx == LP_LAST) ? S_IDLE : S_CLEAR;
      w_idx_nxt   = (r_idx == LP_LAST) ? '0 : r_idx + 1'b1;
    end else if (clear_i) begin
      w_state_nxt = S_CLEAR;
      w_idx_nxt   = '0;
    end
  end
  // Storage: clear sequencer has priority; user writes only land while idle
  always_ff @(posedge clk_i) begin
    if (r_state == S_CLEAR) r_bank[r_idx] <= '0;
    else if (w_we) r_bank[reg_dst_i] <= data_i;
  end
  for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
    logic [SELECT_SIZE-1:0] w_sel;
    assign w_sel = reg_src_i[g*SELECT_SIZE +: SELECT_SIZE];
    assign src_o[g*DATA_WIDTH +: DATA_WIDTH] =
      (busy_o || ({1'b0, w_sel} >= LP_WORDS) || (ZERO_REG != 0 && w_sel == '0)) ? '0 :
      (BYPASS != 0 && w_we && w_sel == reg_dst_i) ? data_i : r_bank[w_sel];
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: scoreboard bench for the default file and a 24-word, no-bypass, no-zero-reg variant
module tb_regfile_multiport;
  logic        clk = 0, reset_i, reg_we_i, clear_i;
  logic [4:0]  reg_dst_i;
  logic [31:0] data_i;
  logic [9:0]  src_sel_m;
  logic [4:0]  src_sel_a;
  logic [63:0] src_m;
  logic [31:0] src_a;
  logic        busy_m, busy_a;
  logic        done = 0;
  int          errors = 0, checks = 0;
  typedef struct {string name; int dut; int port; logic [31:0] exp;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] act;
  always #5 clk = ~clk;
  regfile_multiport u_main (
    .clk_i(clk), .reset_i(reset_i), .reg_we_i(reg_we_i), .reg_dst_i(reg_dst_i),
    .data_i(data_i), .reg_src_i(src_sel_m), .src_o(src_m), .clear_i(clear_i), .busy_o(busy_m));
  regfile_multiport #(.WORDS(24), .READ_PORTS(1), .ZERO_REG(0), .BYPASS(0)) u_alt (
    .clk_i(clk), .reset_i(reset_i), .reg_we_i(reg_we_i), .reg_dst_i(reg_dst_i),
    .data_i(data_i), .reg_src_i(src_sel_a), .src_o(src_a), .clear_i(clear_i), .busy_o(busy_a));
  always @(negedge clk) begin
    while (q.size() != 0) begin
      e = q.pop_front();
      if (e.port < 0) act = {31'b0, (e.dut != 0) ? busy_a : busy_m};
      else act = (e.dut != 0) ? src_a : src_m[e.port*32 +: 32];
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s dut=%0d port=%0d: got %h expected %h", e.name, e.dut, e.port, act, e.exp);
      end
    end
  end
  initial begin
    #100000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: wait expired before the sequence completed");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string n, int d, int p, logic [31:0] v);
    q.push_back('{n, d, p, v});
  endtask
  task automatic sel(int a, int b, int c);
    src_sel_m = {5'(b), 5'(a)};
    src_sel_a = 5'(c);
  endtask
  task automatic busy_window(string n);
    for (int i = 0; i < 32; i++) begin
      chk(n, 0, -1, 1);
      chk(n, 1, -1, (i < 24) ? 1 : 0);
      tick();
    end
    chk(n, 0, -1, 0);
    chk(n, 1, -1, 0);
  endtask
  initial begin
    reset_i = 1; reg_we_i = 1; clear_i = 0; reg_dst_i = 0; data_i = 0; sel(0, 0, 0);
    tick();
    checks++;
    if (busy_m !== 1'b1 || busy_a !== 1'b1 || src_m[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy_m=%b busy_a=%b src0=%h", busy_m, busy_a, src_m[31:0]);
    end
    chk("reset_busy", 0, -1, 1);
    chk("reset_busy", 1, -1, 1);
    chk("reset_rd", 0, 0, 0);
    tick();
    reset_i = 0;
    busy_window("init_busy");
    for (int r = 0; r < 32; r++) begin
      sel(r, r, r);
      chk("init_zero", 0, 0, 0);
      chk("init_zero", 0, 1, 0);
      chk("init_zero", 1, 0, 0);
      tick();
    end
    sel(14, 14, 14); reg_we_i = 0; reg_dst_i = 14; data_i = 32'hBEEFDEAD;
    chk("x14_bypass", 0, 0, 32'hBEEFDEAD);
    chk("x14_bypass", 0, 1, 32'hBEEFDEAD);
    chk("x14_nobypass", 1, 0, 0);
    tick();
    reg_we_i = 1;
    chk("x14_after", 0, 0, 32'hBEEFDEAD);
    chk("x14_after", 0, 1, 32'hBEEFDEAD);
    chk("x14_after", 1, 0, 32'hBEEFDEAD);
    tick();
    sel(0, 0, 0); reg_we_i = 0; reg_dst_i = 0; data_i = 32'h12345678;
    chk("x0_same", 0, 0, 0);
    chk("x0_same", 1, 0, 0);
    tick();
    reg_we_i = 1;
    chk("x0_after", 0, 0, 0);
    chk("x0_after", 1, 0, 32'h12345678);
    tick();
    sel(27, 27, 27); reg_we_i = 0; reg_dst_i = 27; data_i = 32'hAAAA5555;
    chk("sel27_same", 0, 0, 32'hAAAA5555);
    chk("sel27_same", 1, 0, 0);
    tick();
    reg_we_i = 1;
    chk("sel27_after", 0, 0, 32'hAAAA5555);
    chk("sel27_after", 1, 0, 0);
    tick();
    sel(0, 0, 3);
    chk("sel27_alias3", 1, 0, 0);
    tick();
    sel(0, 0, 11);
    chk("sel27_alias11", 1, 0, 0);
    tick();
    for (int r = 1; r < 32; r++) begin
      reg_we_i = 0; reg_dst_i = 5'(r); data_i = r; sel(r, 0, 0);
      chk("fill_bypass", 0, 0, r);
      tick();
    end
    reg_we_i = 1;
    for (int r = 0; r < 32; r++) begin
      sel(r, 31 - r, r);
      chk("fill_rd", 0, 0, r);
      chk("fill_rd", 0, 1, 31 - r);
      chk("fill_rd", 1, 0, (r == 0) ? 32'h12345678 : (r < 24) ? r : 0);
      tick();
    end
    sel(5, 7, 7); clear_i = 1; reg_we_i = 0; reg_dst_i = 5; data_i = 32'h55;
    chk("clr_wr_bypass", 0, 0, 32'h55);
    tick();
    clear_i = 0; reg_dst_i = 7; data_i = 32'hDEAD0007;
    for (int i = 0; i < 32; i++) begin
      reg_we_i = (i < 20) ? 0 : 1;
      clear_i = (i == 10) ? 1 : 0;
      chk("clr_busy", 0, -1, 1);
      chk("clr_busy", 1, -1, (i < 24) ? 1 : 0);
      chk("clr_rd_busy", 0, 1, 0);
      tick();
    end
    reg_we_i = 1; clear_i = 0;
    chk("clr_done", 0, -1, 0);
    chk("clr_done", 1, -1, 0);
    for (int r = 0; r < 32; r++) begin
      sel(r, r, r);
      chk("clr_zero", 0, 0, 0);
      chk("clr_zero", 0, 1, 0);
      chk("clr_zero", 1, 0, 0);
      tick();
    end
    clear_i = 1;
    tick();
    clear_i = 0;
    repeat (10) tick();
    chk("mid_busy", 0, -1, 1);
    reset_i = 1;
    #1;
    chk("mid_rst_busy", 0, -1, 1);
    tick();
    reset_i = 0;
    busy_window("rst_restart");
    @(negedge clk);
    #1;
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the 32x32 CPU register file.
- Adds a configurable number of read ports and an optional write-to-read bypass.
- Adds a hardware clear sequencer that zeroes every register after reset or on request, with a busy flag for the control FSM.
- Sits in the datapath between writeback and operand fetch; the control matrix must hold decode while busy_o is high.

Parameters:
DATA_WIDTH, 32, register width in bits
WORDS, 32, number of registers (need not be a power of 2)
SELECT_SIZE, 5, select width; must satisfy 2**SELECT_SIZE >= WORDS
READ_PORTS, 2, number of independent combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is ordinary storage
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read port

Ports:
clk_i  input  1  single clock; all state changes on posedge
reset_i  input  1  asynchronous, active-high reset
reg_we_i  input  1  write enable, active low
reg_dst_i  input  SELECT_SIZE  write destination select
data_i  input  DATA_WIDTH  write data
reg_src_i  input  READ_PORTS*SELECT_SIZE  packed read selects; port k at bits [k*SELECT_SIZE +: SELECT_SIZE]
src_o  output  READ_PORTS*DATA_WIDTH  packed read data; port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
clear_i  input  1  synchronous request to zero all registers (active high, sampled in IDLE only)
busy_o  output  1  high while the clear sequencer runs

Behaviour:
- Reset:
  - reset_i asserted forces state CLEAR, clear index = 0 and busy_o = 1 immediately (async).
  - Bank contents are not reset directly; the clear sequence zeroes them.
  - Reset asserted mid-clear restarts the clear at index 0.
- FSM states: CLEAR, IDLE.
  - CLEAR: each posedge writes 0 to bank[index], then index increments. When index == WORDS-1 is written, the next state is IDLE and index returns to 0.
  - busy_o = (state == CLEAR), so busy_o is high for exactly WORDS posedges after reset deassertion.
  - IDLE: clear_i = 1 at a posedge moves to CLEAR with index 0; busy_o rises after that edge.
  - clear_i during CLEAR is ignored; there is no restart and no queuing.
- Writes:
  - On posedge, when state == IDLE and reg_we_i == 0 and reg_dst_i < WORDS, bank[reg_dst_i] <= data_i.
  - Write is suppressed when ZERO_REG == 1 and reg_dst_i == 0.
  - Writes while busy_o = 1 are dropped silently.
  - Write and clear_i in the same IDLE cycle: the write lands, then the clear sequence overwrites it.
- Reads (combinational, per port k):
  - busy_o = 1: port reads 0.
  - select >= WORDS: port reads 0.
  - ZERO_REG == 1 and select == 0: port reads 0.
  - BYPASS == 1, a write is qualifying this cycle (IDLE, we low, dst valid, not suppressed) and select == reg_dst_i: port reads data_i.
  - Otherwise: port reads bank[select].
  - Several ports may select the same register; each returns the same value.
  - BYPASS == 0: new data becomes visible only after the write edge.
- Latency:
  - Read is 0-cycle combinational.
  - Write is visible to reads 1 cycle later, or 0 cycles with BYPASS.
  - A full clear takes WORDS cycles.
- No X propagation: all read paths are muxed to defined values under every select.

Test Plan:
- Reset then release; hold reg_we_i high -> busy_o = 1 for exactly 32 posedges, then 0; all 32 registers on all ports read 0x00000000.
- IDLE: write 0xBEEFDEAD to x14, read port0 = 14, port1 = 14 -> both ports read 0xBEEFDEAD the cycle after the write edge; with BYPASS = 1 they read it in the same cycle as the write.
- ZERO_REG = 1: write 0x12345678 to x0 -> port0 on x0 reads 0, including during the bypass cycle. ZERO_REG = 0: the same write reads back 0x12345678.
- Fill x1..x31 with index values, pulse clear_i for 1 cycle -> busy_o high for 32 cycles, writes issued during busy are dropped, and all registers read 0 afterwards. A second clear_i pulse mid-clear does not extend busy beyond 32 cycles.
- Assert reset_i at clear index 10 -> busy_o stays 1 and the sequence restarts at index 0, so busy_o falls 32 cycles after reset release.
- WORDS = 24, SELECT_SIZE = 5: write 0xAAAA5555 to select 27 -> no register changes; read select 27 returns 0.
